// File: rtl/sccb_init_sequencer.sv
// Table-driven SCCB register bring-up: walks WRITE / DELAY / END entries and feeds the SCCB master's
// ctrl, sub-address and data streams. Define SCCB_SEQ_DELAY_EN to enable timed DELAY entries.
module sccb_init_sequencer #(
  parameter int DATA_W       = 8,
  parameter int TBL_ADDR_W   = 8,
  parameter int DLY_UNIT_CYC = 125000,
  parameter int DLY_CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  output logic [TBL_ADDR_W-1:0]   tbl_addr_o,
  input  logic [2+2*DATA_W-1:0]   tbl_data_i,
  output logic [DATA_W-1:0]       ctrl_data_o,
  output logic                    ctrl_vld_o,
  input  logic                    ctrl_rdy_i,
  output logic [DATA_W-1:0]       sub_adr_o,
  output logic                    sub_adr_vld_o,
  input  logic                    sub_adr_rdy_i,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic                    tx_data_vld_o,
  input  logic                    tx_data_rdy_i,
  input  logic                    sccb_idle_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [TBL_ADDR_W-1:0]   wr_cnt_o
);

  localparam int ENTRY_W = 2 + 2*DATA_W;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b10;

  // Write transaction: trans_type=0, phase_amt=3.
  localparam logic [DATA_W-1:0] CTRL_WORD = DATA_W'(3);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_PUSH_DAT, S_PUSH_CTRL,
    S_WAIT_IDLE, S_DELAY, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        entry_op;
  logic [DATA_W-1:0] sub_q, dat_q;
  logic              sub_pend, dat_pend;
  logic              sub_hs, dat_hs, ctrl_hs;
  logic              at_last, advance;

  assign entry_op = tbl_data_i[ENTRY_W-1 -: 2];
  assign sub_hs   = sub_pend & sub_adr_rdy_i;
  assign dat_hs   = dat_pend & tx_data_rdy_i;
  assign ctrl_hs  = ctrl_vld_o & ctrl_rdy_i;
  assign at_last  = (tbl_addr_o == '1);

  assign sub_adr_vld_o = sub_pend;
  assign tx_data_vld_o = dat_pend;
  assign sub_adr_o     = sub_q;
  assign tx_data_o     = dat_q;

`ifdef SCCB_SEQ_DELAY_EN
  logic [DLY_CNT_W-1:0] dly_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_cnt <= '0;
    end else if (state == S_WAIT_IDLE && sccb_idle_i) begin
      // Loaded one short so the DELAY state lasts exactly data*DLY_UNIT_CYC cycles.
      dly_cnt <= DLY_CNT_W'(dat_q) * DLY_CNT_W'(DLY_UNIT_CYC) - DLY_CNT_W'(1);
    end else if (state == S_DELAY && dly_cnt != '0) begin
      dly_cnt <= dly_cnt - DLY_CNT_W'(1);
    end
  end
`endif

  // An entry that finished and should move the table pointer on.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    advance = 1'b0;
    case (state)
      S_PUSH_CTRL: advance = ctrl_hs;
`ifdef SCCB_SEQ_DELAY_EN
      S_WAIT_IDLE: advance = sccb_idle_i && (dat_q == '0);
      S_DELAY:     advance = (dly_cnt == '0);
`else
      S_DECODE:    advance = (entry_op == OP_DELAY);
`endif
      default:     advance = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (entry_op)
          OP_WRITE: state_nxt = S_PUSH_DAT;
`ifdef SCCB_SEQ_DELAY_EN
          OP_DELAY: state_nxt = S_WAIT_IDLE;
`else
          OP_DELAY: state_nxt = S_FETCH;
`endif
          default:  state_nxt = S_DRAIN;
        endcase
      end
      S_PUSH_DAT: begin
        if ((!sub_pend || sub_adr_rdy_i) && (!dat_pend || tx_data_rdy_i))
          state_nxt = S_PUSH_CTRL;
      end
      S_PUSH_CTRL: state_nxt = S_PUSH_CTRL;
`ifdef SCCB_SEQ_DELAY_EN
      S_WAIT_IDLE: if (sccb_idle_i) state_nxt = S_DELAY;
      S_DELAY:     state_nxt = S_DELAY;
`endif
      S_DRAIN:  if (sccb_idle_i) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // The last table slot has no successor: running off it is an error, never a wrap.
    if (advance) state_nxt = at_last ? S_DRAIN : S_FETCH;
  end

  always_comb begin
    busy_o      = 1'b1;
    done_o      = 1'b0;
    ctrl_vld_o  = 1'b0;
    ctrl_data_o = '0;
    case (state)
      S_IDLE: busy_o = 1'b0;
      S_DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
      end
      S_PUSH_CTRL: begin
        ctrl_vld_o  = 1'b1;
        ctrl_data_o = CTRL_WORD;
      end
      default: busy_o = 1'b1;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_addr_o <= '0;
      wr_cnt_o   <= '0;
      err_o      <= 1'b0;
      sub_q      <= '0;
      dat_q      <= '0;
      sub_pend   <= 1'b0;
      dat_pend   <= 1'b0;
    end else begin
      if (state == S_IDLE && start_i) begin
        tbl_addr_o <= '0;
        wr_cnt_o   <= '0;
        err_o      <= 1'b0;
      end
      if (state == S_DECODE) begin
        sub_q <= tbl_data_i[2*DATA_W-1 -: DATA_W];
        dat_q <= tbl_data_i[DATA_W-1:0];
        if (entry_op == OP_WRITE) begin
          sub_pend <= 1'b1;
          dat_pend <= 1'b1;
        end
        if (entry_op == OP_RSVD) err_o <= 1'b1;
      end
      // Sub-address and data streams complete independently of each other.
      if (sub_hs)  sub_pend <= 1'b0;
      if (dat_hs)  dat_pend <= 1'b0;
      if (ctrl_hs) wr_cnt_o <= wr_cnt_o + TBL_ADDR_W'(1);
      if (advance) begin
        if (at_last) err_o      <= 1'b1;
        else         tbl_addr_o <= tbl_addr_o + TBL_ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Self-checking bench for sccb_init_sequencer: directed scenarios plus randomized tables and
// handshake back-pressure, scored against a table-walk reference model.
module tb_sccb_init_sequencer;

  localparam int DATA_W       = 8;
  localparam int TBL_ADDR_W   = 3;
  localparam int DLY_UNIT_CYC = 10;
  localparam int DLY_CNT_W    = 16;
  localparam int DEPTH        = 1 << TBL_ADDR_W;
  localparam int ENTRY_W      = 2 + 2*DATA_W;
  localparam int MAX_CYC      = 2000;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic [TBL_ADDR_W-1:0] tbl_addr_o;
  logic [ENTRY_W-1:0]    tbl_data_i;
  logic [DATA_W-1:0]     ctrl_data_o, sub_adr_o, tx_data_o;
  logic                  ctrl_vld_o, sub_adr_vld_o, tx_data_vld_o;
  logic                  ctrl_rdy_i = 1'b1, sub_adr_rdy_i = 1'b1, tx_data_rdy_i = 1'b1;
  logic                  sccb_idle_i = 1'b1;
  logic                  busy_o, done_o, err_o;
  logic [TBL_ADDR_W-1:0] wr_cnt_o;

  sccb_init_sequencer #(
    .DATA_W(DATA_W), .TBL_ADDR_W(TBL_ADDR_W),
    .DLY_UNIT_CYC(DLY_UNIT_CYC), .DLY_CNT_W(DLY_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .tbl_addr_o(tbl_addr_o), .tbl_data_i(tbl_data_i),
    .ctrl_data_o(ctrl_data_o), .ctrl_vld_o(ctrl_vld_o), .ctrl_rdy_i(ctrl_rdy_i),
    .sub_adr_o(sub_adr_o), .sub_adr_vld_o(sub_adr_vld_o), .sub_adr_rdy_i(sub_adr_rdy_i),
    .tx_data_o(tx_data_o), .tx_data_vld_o(tx_data_vld_o), .tx_data_rdy_i(tx_data_rdy_i),
    .sccb_idle_i(sccb_idle_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wr_cnt_o(wr_cnt_o)
  );

  always #5 clk = ~clk;

  // Synchronous table memory: data follows the address by one clock.
  logic [ENTRY_W-1:0] tbl_mem [DEPTH];
  always @(posedge clk) tbl_data_i <= tbl_mem[tbl_addr_o];

  int errors = 0;
  int checks = 0;

  int rdy_pct, sub_stall, idle_hold_cfg, mid_start_cyc;

  logic [DATA_W-1:0] obs_sub[$], obs_dat[$];
  int   sub_hs_cyc[$], dat_hs_cyc[$], ctrl_hs_cyc[$];
  int   n_ctrl, sub_vld_cyc, dat_vld_cyc, done_cnt, done_cyc, proto_err;
  logic busy_at1, err_at1, addr_at1, timed_out;

  logic [DATA_W-1:0] exp_sub[$], exp_dat[$];
  logic exp_err;
  int   exp_addr;

  function automatic logic [ENTRY_W-1:0] ent(input logic [1:0] op, input logic [DATA_W-1:0] s,
                                             input logic [DATA_W-1:0] d);
    return {op, s, d};
  endfunction

  function automatic int first_diff(input logic [DATA_W-1:0] a[$], input logic [DATA_W-1:0] b[$]);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic int q_at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  // Reference: walk the table by its rules; writes in order, stop at END, reserved or the last slot.
  task automatic model_run();
    logic [1:0] op;
    exp_sub.delete();
    exp_dat.delete();
    exp_err  = 1'b0;
    exp_addr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      op = tbl_mem[i][ENTRY_W-1 -: 2];
      exp_addr = i;
      if (op == 2'b11) break;
      if (op == 2'b10) begin exp_err = 1'b1; break; end
      if (op == 2'b00) begin
        exp_sub.push_back(tbl_mem[i][2*DATA_W-1 -: DATA_W]);
        exp_dat.push_back(tbl_mem[i][DATA_W-1:0]);
      end
      if (i == DEPTH-1) exp_err = 1'b1;
    end
  endtask

  task automatic set_knobs(input int pct, input int stall, input int hold, input int mid);
    rdy_pct = pct; sub_stall = stall; idle_hold_cfg = hold; mid_start_cyc = mid;
  endtask

  task automatic load_basic();
    for (int i = 0; i < DEPTH; i++) tbl_mem[i] = ent(2'b11, 8'h00, 8'h00);
    tbl_mem[0] = ent(2'b00, 8'h12, 8'h80);
    tbl_mem[1] = ent(2'b00, 8'h11, 8'h01);
  endtask

  task automatic hard_reset();
    @(negedge clk); rst = 1'b1; start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the start pulse is sampled.
  task automatic run_seq();
    int cyc, stall_left, hold_left, post;
    logic p_sv, p_sh, p_dv, p_dh, p_cv, p_ch, sh, dh, ch;
    logic [DATA_W-1:0] p_s, p_d, p_c;
    obs_sub.delete(); obs_dat.delete();
    sub_hs_cyc.delete(); dat_hs_cyc.delete(); ctrl_hs_cyc.delete();
    n_ctrl = 0; sub_vld_cyc = 0; dat_vld_cyc = 0; done_cnt = 0; done_cyc = -1; proto_err = 0;
    busy_at1 = 1'b0; err_at1 = 1'b1; addr_at1 = 1'b1; timed_out = 1'b0;
    stall_left = sub_stall; hold_left = 0; post = -1;
    {p_sv, p_sh, p_dv, p_dh, p_cv, p_ch} = '0;
    p_s = '0; p_d = '0; p_c = '0;
    @(negedge clk); start_i = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start_i = (cyc == mid_start_cyc) && busy_o;
      if (hold_left > 0) begin sccb_idle_i = 1'b0; hold_left--; end
      else sccb_idle_i = 1'b1;
      if (sub_adr_vld_o && stall_left > 0) begin sub_adr_rdy_i = 1'b0; stall_left--; end
      else sub_adr_rdy_i = ($urandom_range(99) < rdy_pct);
      tx_data_rdy_i = ($urandom_range(99) < rdy_pct);
      ctrl_rdy_i    = ($urandom_range(99) < rdy_pct);
      if (cyc == 1) begin busy_at1 = busy_o; err_at1 = err_o; addr_at1 = |tbl_addr_o; end
      if (p_sv && !p_sh && (!sub_adr_vld_o || sub_adr_o !== p_s)) proto_err++;
      if (p_dv && !p_dh && (!tx_data_vld_o || tx_data_o !== p_d)) proto_err++;
      if (p_cv && !p_ch && (!ctrl_vld_o || ctrl_data_o !== p_c)) proto_err++;
      sh = sub_adr_vld_o && sub_adr_rdy_i;
      dh = tx_data_vld_o && tx_data_rdy_i;
      ch = ctrl_vld_o && ctrl_rdy_i;
      if (sub_adr_vld_o) sub_vld_cyc++;
      if (tx_data_vld_o) dat_vld_cyc++;
      if (sh) begin obs_sub.push_back(sub_adr_o); sub_hs_cyc.push_back(cyc); end
      if (dh) begin obs_dat.push_back(tx_data_o); dat_hs_cyc.push_back(cyc); end
      if (ch) begin
        n_ctrl++;
        ctrl_hs_cyc.push_back(cyc);
        if (ctrl_data_o !== 8'h03 || n_ctrl > obs_sub.size() || n_ctrl > obs_dat.size()) proto_err++;
        hold_left = idle_hold_cfg;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy_o) proto_err++;
        if (post < 0) post = 2;
      end
      {p_sv, p_sh, p_dv, p_dh, p_cv, p_ch} = {sub_adr_vld_o, sh, tx_data_vld_o, dh, ctrl_vld_o, ch};
      p_s = sub_adr_o; p_d = tx_data_o; p_c = ctrl_data_o;
      if (post == 0) break;
      if (post > 0) post--;
      if (cyc >= MAX_CYC) begin timed_out = 1'b1; break; end
    end
    start_i = 1'b0; sub_adr_rdy_i = 1'b1; tx_data_rdy_i = 1'b1; ctrl_rdy_i = 1'b1; sccb_idle_i = 1'b1;
    if (timed_out) hard_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ctrl_vld_o, sub_adr_vld_o, tx_data_vld_o, busy_o, done_o, err_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
                         {ctrl_vld_o, sub_adr_vld_o, tx_data_vld_o, busy_o, done_o, err_o});
    end
    checks++;
    if ({tbl_addr_o, wr_cnt_o, ctrl_data_o, sub_adr_o, tx_data_o} !== '0) begin
      errors++; $display("FAIL reset_words: addr=%0d cnt=%0d ctrl=%h sub=%h dat=%h want all 0",
                         tbl_addr_o, wr_cnt_o, ctrl_data_o, sub_adr_o, tx_data_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int d;
    load_basic(); model_run(); set_knobs(100, 0, 0, -1);
    run_seq();
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: no done within %0d cycles", MAX_CYC); end
    d = first_diff(obs_sub, exp_sub);
    checks++; if (d != -1) begin errors++; $display("FAIL basic_sub: got %0d items want %0d (diff %0d)", obs_sub.size(), exp_sub.size(), d); end
    d = first_diff(obs_dat, exp_dat);
    checks++; if (d != -1) begin errors++; $display("FAIL basic_dat: got %0d items want %0d (diff %0d)", obs_dat.size(), exp_dat.size(), d); end
    checks++; if (n_ctrl !== 2 || proto_err !== 0) begin errors++; $display("FAIL basic_ctrl: got %0d ctrl, %0d protocol faults want 2, 0", n_ctrl, proto_err); end
    checks++; if (wr_cnt_o !== 3'd2 || err_o !== 1'b0) begin errors++; $display("FAIL basic_status: wr_cnt=%0d err=%b want 2, 0", wr_cnt_o, err_o); end
    checks++; if (busy_at1 !== 1'b1 || addr_at1 !== 1'b0) begin errors++; $display("FAIL basic_start: busy=%b addr_nz=%b want 1, 0", busy_at1, addr_at1); end
    // Four cycles per WRITE: data push in cycle 3+4i, ctrl in 4+4i, done after END fetch+decode+drain.
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (q_at(sub_hs_cyc, i) != 3+4*i || q_at(ctrl_hs_cyc, i) != 4+4*i) begin
        errors++; $display("FAIL basic_timing%0d: sub@%0d ctrl@%0d want %0d, %0d", i,
                           q_at(sub_hs_cyc, i), q_at(ctrl_hs_cyc, i), 3+4*i, 4+4*i);
      end
    end
    checks++; if (done_cnt != 1 || done_cyc != 12) begin errors++; $display("FAIL basic_done: %0d pulses at %0d want 1 at 12", done_cnt, done_cyc); end
  endtask

  task automatic test_split_handshake();
    load_basic(); model_run(); set_knobs(100, 5, 0, -1);
    run_seq();
    checks++; if (timed_out) begin errors++; $display("FAIL split_timeout: no done within %0d cycles", MAX_CYC); end
    checks++;
    if (q_at(dat_hs_cyc, 0) != 3 || q_at(sub_hs_cyc, 0) != 8 || q_at(ctrl_hs_cyc, 0) != 9) begin
      errors++; $display("FAIL split_order: dat@%0d sub@%0d ctrl@%0d want 3, 8, 9",
                         q_at(dat_hs_cyc, 0), q_at(sub_hs_cyc, 0), q_at(ctrl_hs_cyc, 0));
    end
    // First write: data valid 1 cycle, sub-address 6; second write: 1 cycle each.
    checks++; if (dat_vld_cyc != 2 || sub_vld_cyc != 7) begin errors++; $display("FAIL split_vld_len: dat=%0d sub=%0d want 2, 7", dat_vld_cyc, sub_vld_cyc); end
    checks++; if (first_diff(obs_sub, exp_sub) != -1 || proto_err != 0) begin errors++; $display("FAIL split_content: %0d subs, %0d protocol faults", obs_sub.size(), proto_err); end
  endtask

  task automatic test_delay();
    int exp_done;
    for (int i = 0; i < DEPTH; i++) tbl_mem[i] = ent(2'b11, 8'h00, 8'h00);
    tbl_mem[0] = ent(2'b00, 8'h12, 8'h80);
    tbl_mem[1] = ent(2'b01, 8'h00, 8'd3);
    set_knobs(100, 0, 7, -1);
    run_seq();
    // Write ctrl at 4, bus busy 5..11, idle seen at 12.
`ifdef SCCB_SEQ_DELAY_EN
    exp_done = 12 + 1 + 3*DLY_UNIT_CYC + 3;
`else
    exp_done = 12 + 1;
`endif
    checks++; if (timed_out) begin errors++; $display("FAIL delay_timeout: no done within %0d cycles", MAX_CYC); end
    checks++; if (done_cnt != 1 || done_cyc != exp_done) begin errors++; $display("FAIL delay_done: %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, exp_done); end
    checks++; if (wr_cnt_o !== 3'd1 || err_o !== 1'b0 || tbl_addr_o !== 3'd2) begin errors++; $display("FAIL delay_status: cnt=%0d err=%b addr=%0d want 1, 0, 2", wr_cnt_o, err_o, tbl_addr_o); end
  endtask

  task automatic test_reserved();
    for (int i = 0; i < DEPTH; i++) tbl_mem[i] = ent(2'b11, 8'h00, 8'h00);
    tbl_mem[0] = ent(2'b00, 8'h12, 8'h80);
    tbl_mem[1] = ent(2'b10, 8'h55, 8'hAA);
    tbl_mem[2] = ent(2'b00, 8'h11, 8'h01);
    model_run(); set_knobs(100, 0, 0, -1);
    run_seq();
    checks++; if (err_o !== exp_err || tbl_addr_o !== TBL_ADDR_W'(exp_addr)) begin errors++; $display("FAIL rsvd_err: err=%b addr=%0d want %b, %0d", err_o, tbl_addr_o, exp_err, exp_addr); end
    checks++; if (first_diff(obs_sub, exp_sub) != -1 || n_ctrl != 1 || done_cnt != 1) begin errors++; $display("FAIL rsvd_pushes: subs=%0d ctrl=%0d done=%0d want 1, 1, 1", obs_sub.size(), n_ctrl, done_cnt); end
    load_basic(); model_run();
    run_seq();
    checks++; if (err_at1 !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL rsvd_clear: err at start=%b at end=%b want 0, 0", err_at1, err_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) tbl_mem[i] = ent(2'b00, DATA_W'($urandom), DATA_W'($urandom));
    model_run(); set_knobs(100, 0, 0, -1);
    run_seq();
    checks++; if (first_diff(obs_dat, exp_dat) != -1 || n_ctrl != DEPTH) begin errors++; $display("FAIL ovf_writes: dat=%0d ctrl=%0d want %0d", obs_dat.size(), n_ctrl, DEPTH); end
    checks++; if (err_o !== 1'b1 || tbl_addr_o !== TBL_ADDR_W'(DEPTH-1)) begin errors++; $display("FAIL ovf_err: err=%b addr=%0d want 1, %0d", err_o, tbl_addr_o, DEPTH-1); end
    checks++; if (wr_cnt_o !== TBL_ADDR_W'(DEPTH) || done_cnt != 1) begin errors++; $display("FAIL ovf_cnt: cnt=%0d done=%0d want %0d, 1", wr_cnt_o, done_cnt, DEPTH % DEPTH); end
  endtask

  task automatic test_start_ignored();
    load_basic(); model_run(); set_knobs(100, 0, 0, 6);
    run_seq();
    checks++; if (first_diff(obs_sub, exp_sub) != -1 || q_at(ctrl_hs_cyc, 1) != 8 || done_cyc != 12) begin
      errors++; $display("FAIL busy_start: subs=%0d ctrl1@%0d done@%0d want 2, 8, 12", obs_sub.size(), q_at(ctrl_hs_cyc, 1), done_cyc);
    end
  endtask

  task automatic test_rst_mid();
    load_basic();
    @(negedge clk); start_i = 1'b1; sub_adr_rdy_i = 1'b0;
    @(negedge clk); start_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sub_adr_vld_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: sub_vld=%b busy=%b want 1, 1", sub_adr_vld_o, busy_o); end
    rst = 1'b1;
    #1;
    checks++; if ({sub_adr_vld_o, tx_data_vld_o, ctrl_vld_o, busy_o} !== 4'b0) begin errors++; $display("FAIL rstmid_vld: got %b want 0000", {sub_adr_vld_o, tx_data_vld_o, ctrl_vld_o, busy_o}); end
    checks++; if ({tbl_addr_o, wr_cnt_o} !== '0) begin errors++; $display("FAIL rstmid_cnt: addr=%0d cnt=%0d want 0, 0", tbl_addr_o, wr_cnt_o); end
    @(negedge clk); rst = 1'b0; sub_adr_rdy_i = 1'b1;
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(99);
        if (r < 70)      tbl_mem[i] = ent(2'b00, DATA_W'($urandom), DATA_W'($urandom));
        else if (r < 85) tbl_mem[i] = ent(2'b01, DATA_W'($urandom), DATA_W'($urandom_range(2)));
        else if (r < 90) tbl_mem[i] = ent(2'b10, DATA_W'($urandom), DATA_W'($urandom));
        else             tbl_mem[i] = ent(2'b11, DATA_W'($urandom), DATA_W'($urandom));
      end
      model_run();
      set_knobs($urandom_range(40, 100), 0, $urandom_range(6), $urandom_range(2, 10));
      run_seq();
      checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: no done within %0d cycles", it, MAX_CYC); end
      checks++; if (first_diff(obs_sub, exp_sub) != -1 || first_diff(obs_dat, exp_dat) != -1) begin
        errors++; $display("FAIL rand%0d_data: subs=%0d dats=%0d want %0d", it, obs_sub.size(), obs_dat.size(), exp_sub.size());
      end
      checks++; if (n_ctrl != exp_sub.size() || wr_cnt_o !== TBL_ADDR_W'(exp_sub.size())) begin
        errors++; $display("FAIL rand%0d_cnt: ctrl=%0d cnt=%0d want %0d", it, n_ctrl, wr_cnt_o, exp_sub.size());
      end
      checks++; if (err_o !== exp_err || tbl_addr_o !== TBL_ADDR_W'(exp_addr)) begin
        errors++; $display("FAIL rand%0d_end: err=%b addr=%0d want %b, %0d", it, err_o, tbl_addr_o, exp_err, exp_addr);
      end
      checks++; if (done_cnt != 1 || proto_err != 0) begin
        errors++; $display("FAIL rand%0d_proto: done=%0d faults=%0d want 1, 0", it, done_cnt, proto_err);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) tbl_mem[i] = '1;
    set_knobs(100, 0, 0, -1);
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_split_handshake();
    test_delay();
    test_reserved();
    test_overflow();
    test_start_ignored();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_init_sequencer.md
# sccb_init_sequencer

Autonomous table-driven sequencer that feeds the SCCB master's TX streams (control, sub-address, data) from an external synchronous init table, so a sensor's register bring-up runs without processor involvement. It sits between a table ROM/RAM and the SCCB master's TX FIFO write ports, in parallel with the AXI4 path. Each table entry is a register write, a timed delay, or an end marker; the block walks the table, pushes writes, waits for bus idle before delays, and reports completion or error.

## Interface
- DATA_W, 8, SCCB data/sub-address width
- TBL_ADDR_W, 8, table address width; table depth is 2^TBL_ADDR_W entries
- DLY_UNIT_CYC, 125000, clk cycles per delay unit (1 ms at 125 MHz)
- DLY_CNT_W, 32, delay counter width; must hold 255*DLY_UNIT_CYC
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start_i  in  1  one-cycle start pulse; ignored unless idle
- tbl_addr_o  out  TBL_ADDR_W  table read address
- tbl_data_i  in  2+2*DATA_W  entry {op[1:0], sub_adr, data}; valid 1 cycle after tbl_addr_o
- ctrl_data_o  out  DATA_W  control word to SCCB ctrl FIFO
- ctrl_vld_o / ctrl_rdy_i  out / in  1  ctrl stream handshake
- sub_adr_o  out  DATA_W  sub-address to SCCB sub-address FIFO
- sub_adr_vld_o / sub_adr_rdy_i  out / in  1  sub-address handshake
- tx_data_o  out  DATA_W  write data to SCCB TX data FIFO
- tx_data_vld_o / tx_data_rdy_i  out / in  1  data handshake
- sccb_idle_i  in  1  SCCB FSM idle and all TX FIFOs empty
- busy_o  out  1  high from the cycle after accepted start until done
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error; cleared on next accepted start
- wr_cnt_o  out  TBL_ADDR_W  count of writes issued in the current run

## Operation
- Reset: all outputs 0, state IDLE.
- Ops: 2'b00 WRITE, 2'b01 DELAY (data = units), 2'b11 END, 2'b10 reserved → treated as END with err_o=1.
- States: IDLE → FETCH → DECODE → {PUSH_DAT → PUSH_CTRL | WAIT_IDLE → DELAY | DRAIN} → FETCH or DONE → IDLE.
- IDLE: start_i → tbl_addr_o=0, wr_cnt_o=0, err_o=0, FETCH.
- FETCH: one cycle, table read in flight. DECODE: latch tbl_data_i, branch by op.
- PUSH_DAT: sub_adr_vld_o and tx_data_vld_o raised together; each drops independently on its own vld&rdy; leave when both accepted.
- PUSH_CTRL: ctrl_data_o = {5'b0, trans_type=0, phase_amt=2'd3}; on handshake wr_cnt_o+1, advance.
- Advance: if tbl_addr_o == 2^TBL_ADDR_W-1, set err_o (no END), go DRAIN; else tbl_addr_o+1, FETCH. Address never wraps.
- WAIT_IDLE: hold until sccb_idle_i=1, then load counter = data*DLY_UNIT_CYC; DELAY counts down to 0 then advances. data=0 → advance the cycle after idle seen.
- END / error: DRAIN waits for sccb_idle_i, then DONE (done_o=1 one cycle), busy_o=0, IDLE.
- Valid outputs never drop before handshake; payloads stable while valid.
- start_i while busy_o=1: ignored. Reset mid-operation: valids drop immediately, counters clear, IDLE.

## Timing
- start_i at cycle N → busy_o=1, state FETCH at N+1; tbl_data_i sampled at N+2.
- WRITE with all rdy=1: 4 cycles per entry (FETCH, DECODE, PUSH_DAT, PUSH_CTRL).
- DELAY of k units, sccb_idle_i already 1: FETCH+DECODE+1 idle-check + k*DLY_UNIT_CYC cycles.
- done_o asserted in the cycle busy_o falls.

## Configuration
- SCCB_SEQ_DELAY_EN defined: DELAY op behaves as above.
- Undefined: no delay counter; DELAY op is a NOP (advance directly from DECODE, no idle wait); WRITE/END unchanged.

## Test plan
- Table {W 0x12/0x80, W 0x11/0x01, END}, all rdy=1, idle=1 → sub_adr 0x12,0x11; data 0x80,0x01; ctrl 0x03 twice; wr_cnt_o=2; done_o pulse; err_o=0.
- Same table, sub_adr_rdy_i held low 5 cycles, tx_data_rdy_i immediate → tx_data_vld_o drops after 1 cycle, sub_adr_vld_o held 6 cycles, ctrl only after both.
- DLY_UNIT_CYC=10, {W, DELAY 3, END}, sccb_idle_i low 7 cycles after write → counter starts after idle, 30-cycle delay, then DONE.
- Table op 2'b10 at entry 1 → err_o=1, done_o pulse, no further pushes; next start_i clears err_o.
- TBL_ADDR_W=2, four WRITEs no END → 4 writes, err_o=1, tbl_addr_o stops at 3.
- rst asserted during PUSH_DAT with vlds high → all valids 0 that cycle, busy_o=0; start_i while busy ignored.
